// File: rtl/upsample_pkg.sv
// upsample_pkg: definitions shared by the upsampler and the pulse-shaping FIR.
//   state_e       - upsampler FSM encoding (IDLE waits for a frame, EMIT streams L beats)
//   DEFAULT_*     - default sample geometry (I/Q, 16-bit) shared with the FIR
//   clamp_factor  - maps a raw runtime factor onto the supported range 1..max_f
package upsample_pkg;

  localparam int DEFAULT_SAMPLE_WIDTH = 16;
  localparam int DEFAULT_CHANNELS     = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // A factor of 0 is meaningless, so it behaves as 1 (pass-through);
  // anything above the supported maximum saturates.
  function automatic int unsigned clamp_factor(input int unsigned f, input int unsigned max_f);
    if (f == 0) begin
      return 1;
    end else if (f > max_f) begin
      return max_f;
    end else begin
      return f;
    end
  endfunction

endpackage

// File: rtl/upsample_stream.sv
// upsample_stream: multi-channel integer upsampler with runtime factor L.
// Each accepted input frame produces L output frames; phase 0 carries the
// real sample, phases 1..L-1 carry zeros (zero-stuff) or a copy (hold).
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   cfg_factor, cfg_hold  - factor L and mode, sampled at input acceptance
//   s_valid/s_ready/s_data          - input frame stream (channel 0 in LSBs)
//   m_valid/m_ready/m_data/m_first  - output frame stream, m_first on phase 0
//   underrun, clr_underrun          - sticky starvation flag and its clear
module upsample_stream
  import upsample_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int CHANNELS     = DEFAULT_CHANNELS,
  parameter int MAX_FACTOR   = 16,
  parameter int FACTOR_W     = $clog2(MAX_FACTOR + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [FACTOR_W-1:0]              cfg_factor,
  input  logic                             cfg_hold,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] s_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [CHANNELS*SAMPLE_WIDTH-1:0] m_data,
  output logic                             m_first,
  output logic                             underrun,
  input  logic                             clr_underrun
);

  localparam int DATA_W = CHANNELS * SAMPLE_WIDTH;

  state_e              state_q;
  logic [FACTOR_W-1:0] phase_q;
  logic [FACTOR_W-1:0] factor_q;
  logic                hold_q;
  logic [DATA_W-1:0]   held_q;
  logic                m_valid_q;
  logic [DATA_W-1:0]   m_data_q;
  logic                m_first_q;
  logic                underrun_q;
  logic                armed_q;

  logic [FACTOR_W-1:0] factor_d;
  logic [DATA_W-1:0]   fill_data_d;
  logic                last_phase;
  logic                in_hs;
  logic                out_hs;

  assign factor_d   = FACTOR_W'(clamp_factor(32'(cfg_factor), 32'(MAX_FACTOR)));
  assign last_phase = (phase_q == factor_q - FACTOR_W'(1));
  assign out_hs     = m_valid_q && m_ready;

  // Accepting on the last beat of a burst lets the next burst start
  // without an idle cycle on the output.
  assign s_ready = !rst && ((state_q == ST_IDLE) || (out_hs && last_phase));
  assign in_hs   = s_valid && s_ready;

  // Data for phases 1..L-1: each channel is either the held sample or zero.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_fill
    assign fill_data_d[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
      hold_q ? held_q[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      factor_q   <= FACTOR_W'(1);
      hold_q     <= 1'b0;
      held_q     <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_first_q  <= 1'b0;
      underrun_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      // Clear has priority over a set in the same cycle.
      if (clr_underrun) begin
        underrun_q <= 1'b0;
      end else if (armed_q && (state_q == ST_IDLE) && m_ready) begin
        underrun_q <= 1'b1;
      end

      if (in_hs) begin
        // New frame: from IDLE, or chained onto the final beat of a burst.
        armed_q   <= 1'b1;
        held_q    <= s_data;
        factor_q  <= factor_d;
        hold_q    <= cfg_hold;
        phase_q   <= '0;
        state_q   <= ST_EMIT;
        m_valid_q <= 1'b1;
        m_data_q  <= s_data;
        m_first_q <= 1'b1;
      end else if (out_hs) begin
        if (!last_phase) begin
          phase_q   <= phase_q + FACTOR_W'(1);
          m_data_q  <= fill_data_d;
          m_first_q <= 1'b0;
        end else begin
          state_q   <= ST_IDLE;
          phase_q   <= '0;
          m_valid_q <= 1'b0;
          m_data_q  <= '0;
          m_first_q <= 1'b0;
        end
      end
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_first  = m_first_q;
  assign underrun = underrun_q;

endmodule

// File: doc/upsample_stream.md
Name: upsample_stream

Overview:
- Parametrised multi-channel integer upsampler. Successor to the fixed-factor zero-stuffing upsampler.
- Takes one sample frame per input handshake and emits L output frames, with L set at runtime.
- Mode selects zero-stuffing (for the following interpolation FIR) or zero-order hold.
- Sits between the symbol mapper and the pulse-shaping filter / DAC feed.
- Valid/ready on both sides; a sticky underrun flag reports starvation of the downstream consumer.

Parameters:
- SAMPLE_WIDTH, 16, bits per channel sample
- CHANNELS, 2, channels packed per frame (e.g. I/Q)
- MAX_FACTOR, 16, largest supported upsample factor L
- FACTOR_W, $clog2(MAX_FACTOR+1), width of the cfg_factor port

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cfg_factor  in  FACTOR_W  upsample factor L; 0 is treated as 1, values above MAX_FACTOR clamp to MAX_FACTOR
- cfg_hold  in  1  0 = zero-stuff, 1 = repeat sample (zero-order hold)
- s_valid  in  1  input frame valid
- s_ready  out  1  input frame accepted when s_valid && s_ready
- s_data  in  CHANNELS*SAMPLE_WIDTH  input frame; channel 0 in the LSBs
- m_valid  out  1  output frame valid
- m_ready  in  1  downstream accepts the output frame
- m_data  out  CHANNELS*SAMPLE_WIDTH  output frame
- m_first  out  1  high on phase 0, i.e. the frame carrying the real sample
- underrun  out  1  sticky: downstream was ready but no frame was available
- clr_underrun  in  1  clears underrun

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, phase=0, held frame=0, m_valid=0, m_data=0, m_first=0, underrun=0, armed=0. Reset mid-burst abandons the burst with no further output.
- s_ready = !rst && (state==IDLE || (m_valid && m_ready && phase==L_lat-1)). This allows back-to-back bursts with no bubble.
- States:
  - IDLE: m_valid=0. On an input handshake: latch s_data, latch L_lat=clamp(cfg_factor) and mode_lat=cfg_hold, set phase=0, go to EMIT. m_valid rises the next cycle (latency 1).
  - EMIT: m_valid=1.
    - Phase 0: m_data=held frame, m_first=1.
    - Phases 1..L_lat-1: m_data = held frame if mode_lat else all zeros; m_first=0.
    - On m_valid && m_ready: if phase<L_lat-1, phase increments. Otherwise, if an input handshake occurs in the same cycle, load the new frame/config with phase=0 and stay in EMIT; else go to IDLE.
- m_data and m_first are held stable while m_valid && !m_ready.
- Config is sampled only at input acceptance. Changes mid-burst take effect on the next frame.
- L_lat=1: every output is the input frame with m_first=1; this is a pass-through with 1-cycle latency and full throughput.
- armed is set on the first accepted input after reset.
- underrun sets when armed && state==IDLE && m_ready && !rst. It stays set until clr_underrun=1 (clear wins over a same-cycle set) or rst.
- No arithmetic on samples: no gain compensation is applied in zero-stuff mode; the downstream FIR carries the gain of L. Phase counter width is FACTOR_W and never exceeds L_lat-1.

Decomposition:
- Shared package (upsample_pkg): state encoding (IDLE, EMIT), clamp-factor function, default SAMPLE_WIDTH/CHANNELS constants shared with the pulse-shaping FIR.
- No sub-module required. The phase counter stays inline; the per-channel zero/hold mux is a generate loop, not a separate module.

Test Plan:
- L=4, zero-stuff, m_ready=1, inputs 0x1234/0xABCD then 0x0001/0x0002 back-to-back -> outputs {0x1234/0xABCD,0,0,0,0x0001/0x0002,0,0,0}, m_first on frames 0 and 4, s_ready high only in IDLE and on phase 3, no bubble.
- L=3, hold mode, m_ready toggling 1,0,1,0 -> each input frame appears exactly 3 times, data stable during stalls, total beats = 3 × inputs.
- cfg_factor=0 and cfg_factor=MAX_FACTOR+5 -> behaves as L=1 (1 output per input) and L=MAX_FACTOR (16 outputs per input) respectively.
- Change cfg_factor 4→2 during phase 1 of a burst -> current burst still emits 4 frames; next burst emits 2.
- After the first input, let input starve for 3 cycles with m_ready=1 -> underrun=1 and stays set; clr_underrun pulse -> 0. Before any input, underrun remains 0.
- Assert rst at phase 2 of an L=8 burst -> next cycle m_valid=0, m_data=0, state IDLE; a new input then starts cleanly at phase 0.
